// File: rtl/serial_paralelo_align.sv
// Serial-to-parallel byte aligner: hunts for four consecutive 0xBC (COM) bytes, then emits non-COM bytes.
// Optional macro SYNC_LOSS_EN: drop lock after 16 consecutive non-COM bytes.
module serial_paralelo_align (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned COM_W  = 3;
    localparam logic [BYTE_W-1:0] COM_CHAR = 8'hBC;
    localparam logic [BIT_W-1:0]  LAST_BIT = 3'd7;
    // com_cnt value seen on the edge that counts the 4th COM
    localparam logic [COM_W-1:0]  COM_LOCK = 3'd3;
`ifdef SYNC_LOSS_EN
    localparam int unsigned LOSS_W = 5;
    localparam logic [LOSS_W-1:0] LOSS_LIMIT = 5'd16;
`endif

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        LOCKING = 2'b01,
        ACTIVE  = 2'b10
    } state_e;

    state_e              state_q;
    logic [BYTE_W-1:0]   shreg_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [COM_W-1:0]    com_cnt_q;
    logic [BYTE_W-1:0]   data_q;
    logic                valid_q;
    logic                active_q;
`ifdef SYNC_LOSS_EN
    logic [LOSS_W-1:0]   loss_cnt_q;
`endif

    logic [BYTE_W-1:0]   cand_c;
    logic                boundary_c;
    logic                is_com_c;

    assign cand_c     = {shreg_q[BYTE_W-2:0], data_in};
    assign boundary_c = (bit_cnt_q == LAST_BIT);
    assign is_com_c   = (cand_c == COM_CHAR);

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

    // Alignment FSM with registered outputs
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            com_cnt_q  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
`ifdef SYNC_LOSS_EN
            loss_cnt_q <= '0;
`endif
        end else begin
            shreg_q <= cand_c;
            if (state_q != HUNT) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            case (state_q)
                HUNT: begin
                    valid_q  <= 1'b0;
                    active_q <= 1'b0;
                    if (is_com_c) begin
                        state_q   <= LOCKING;
                        com_cnt_q <= 3'd1;
                        bit_cnt_q <= '0;
                    end
                end
                LOCKING: begin
                    valid_q <= 1'b0;
                    if (boundary_c) begin
                        if (is_com_c) begin
                            com_cnt_q <= com_cnt_q + 3'd1;
                            if (com_cnt_q == COM_LOCK) begin
                                state_q  <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= HUNT;
                            com_cnt_q <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (boundary_c) begin
`ifdef SYNC_LOSS_EN
                        if (loss_cnt_q == LOSS_LIMIT) begin
                            state_q    <= HUNT;
                            active_q   <= 1'b0;
                            valid_q    <= 1'b0;
                            com_cnt_q  <= '0;
                            bit_cnt_q  <= '0;
                            loss_cnt_q <= '0;
                        end else if (is_com_c) begin
                            valid_q    <= 1'b0;
                            loss_cnt_q <= '0;
                        end else begin
                            data_q     <= cand_c;
                            valid_q    <= 1'b1;
                            loss_cnt_q <= loss_cnt_q + 5'd1;
                        end
`else
                        if (is_com_c) begin
                            valid_q <= 1'b0;
                        end else begin
                            data_q  <= cand_c;
                            valid_q <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                    state_q   <= HUNT;
                    bit_cnt_q <= '0;
                    com_cnt_q <= '0;
                    valid_q   <= 1'b0;
                    active_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo_align.sv
// Directed self-checking bench for serial_paralelo_align (lock, data, gaps, reset, sync loss).
module tb_serial_paralelo_align;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic seen12   = 1'b0;

    serial_paralelo_align dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active)
    );

    always #5 clk_32f = ~clk_32f;

    // Drive one bit, let the rising edge sample it, return 1 time unit later
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        if (valid_out === 1'b1 && data_out === 8'h12) seen12 = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        data_in = 1'b0;
        reset   = 1'b1;
        @(posedge clk_32f);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_checks++; if (data_out !== 8'h00) $display("FAIL reset_async_data got %h exp 00", data_out); else n_pass++;
        n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_async_valid got %b exp 0", valid_out); else n_pass++;
        n_checks++; if (active !== 1'b0) $display("FAIL reset_async_active got %b exp 0", active); else n_pass++;
        @(posedge clk_32f);
        @(posedge clk_32f);
        #1 reset = 1'b0;
        send_byte(8'h00);
        n_checks++; if (active !== 1'b0 || valid_out !== 1'b0) $display("FAIL reset_idle got active=%b valid=%b exp 0/0", active, valid_out); else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] v;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hBC);
            n_checks++; if (active !== 1'b0) $display("FAIL basic_early_active byte%0d got %b exp 0", k, active); else n_pass++;
        end
        v = 8'hBC;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        n_checks++; if (active !== 1'b0) $display("FAIL basic_active_before_edge got %b exp 0", active); else n_pass++;
        send_bit(v[0]);
        n_checks++; if (active !== 1'b1) $display("FAIL basic_active_on_4th got %b exp 1", active); else n_pass++;
        n_checks++; if (valid_out !== 1'b0) $display("FAIL basic_valid_on_lock got %b exp 0", valid_out); else n_pass++;
        send_byte(8'h5A);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 8'h5A) $display("FAIL basic_5a got valid=%b data=%h exp 1/5a", valid_out, data_out); else n_pass++;
        v = 8'hC3;
        for (int i = 7; i >= 1; i--) begin
            send_bit(v[i]);
            n_checks++; if (valid_out !== 1'b1 || data_out !== 8'h5A) $display("FAIL basic_hold bit%0d got valid=%b data=%h exp 1/5a", i, valid_out, data_out); else n_pass++;
        end
        send_bit(v[0]);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 8'hC3) $display("FAIL basic_c3 got valid=%b data=%h exp 1/c3", valid_out, data_out); else n_pass++;
    endtask

    task automatic test_misaligned();
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        n_checks++; if (active !== 1'b1) $display("FAIL misalign_lock got %b exp 1", active); else n_pass++;
        send_byte(8'h81);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 8'h81) $display("FAIL misalign_81 got valid=%b data=%h exp 1/81", valid_out, data_out); else n_pass++;
    endtask

    task automatic test_false_lock();
        do_reset();
        seen12 = 1'b0;
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h12);
        n_checks++; if (active !== 1'b0 || valid_out !== 1'b0) $display("FAIL false_after_12 got active=%b valid=%b exp 0/0", active, valid_out); else n_pass++;
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        n_checks++; if (active !== 1'b0) $display("FAIL false_3com_active got %b exp 0", active); else n_pass++;
        send_byte(8'hBC);
        n_checks++; if (active !== 1'b1) $display("FAIL false_relock got %b exp 1", active); else n_pass++;
        n_checks++; if (seen12 !== 1'b0) $display("FAIL false_12_presented got %b exp 0", seen12); else n_pass++;
    endtask

    task automatic test_com_gap();
        send_byte(8'h11);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 8'h11) $display("FAIL gap_11 got valid=%b data=%h exp 1/11", valid_out, data_out); else n_pass++;
        send_byte(8'hBC);
        n_checks++; if (valid_out !== 1'b0 || data_out !== 8'h11) $display("FAIL gap_com got valid=%b data=%h exp 0/11", valid_out, data_out); else n_pass++;
        send_byte(8'h22);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 8'h22) $display("FAIL gap_22 got valid=%b data=%h exp 1/22", valid_out, data_out); else n_pass++;
    endtask

    task automatic test_reset_mid();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (data_out !== 8'h00 || valid_out !== 1'b0 || active !== 1'b0) $display("FAIL mid_reset got data=%h valid=%b active=%b exp 00/0/0", data_out, valid_out, active); else n_pass++;
        @(posedge clk_32f);
        #1;
        reset   = 1'b0;
        data_in = 1'b0;
        for (int k = 0; k < 3; k++) send_byte(8'hBC);
        send_byte(8'h44);
        n_checks++; if (valid_out !== 1'b0 || active !== 1'b0) $display("FAIL mid_no_relock got valid=%b active=%b exp 0/0", valid_out, active); else n_pass++;
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        n_checks++; if (active !== 1'b1 || valid_out !== 1'b0) $display("FAIL mid_relock got active=%b valid=%b exp 1/0", active, valid_out); else n_pass++;
        send_byte(8'h44);
        n_checks++; if (valid_out !== 1'b1 || data_out !== 8'h44) $display("FAIL mid_44 got valid=%b data=%h exp 1/44", valid_out, data_out); else n_pass++;
    endtask

    task automatic test_sync_loss();
        logic [7:0] v;
        do_reset();
        for (int k = 0; k < 4; k++) send_byte(8'hBC);
        for (int k = 0; k < 10; k++) send_byte(8'(32'h40 + k));
        send_byte(8'hBC);
        for (int k = 0; k < 16; k++) send_byte(8'(32'h20 + k));
        n_checks++; if (active !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'h2F) $display("FAIL loss_16th got active=%b valid=%b data=%h exp 1/1/2f", active, valid_out, data_out); else n_pass++;
        v = 8'h30;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        n_checks++; if (active !== 1'b1 || valid_out !== 1'b1) $display("FAIL loss_hold got active=%b valid=%b exp 1/1", active, valid_out); else n_pass++;
        send_bit(v[0]);
`ifdef SYNC_LOSS_EN
        n_checks++; if (active !== 1'b0 || valid_out !== 1'b0) $display("FAIL loss_drop got active=%b valid=%b exp 0/0", active, valid_out); else n_pass++;
`else
        n_checks++; if (active !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'h30) $display("FAIL loss_keep got active=%b valid=%b data=%h exp 1/1/30", active, valid_out, data_out); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_misaligned();
        test_false_lock();
        test_com_gap();
        test_reset_mid();
        test_sync_loss();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
